// File: rtl/sipo_pkg.sv
// Shared types for the serial-to-parallel collector: default word width and FSM state encodings.
// No logic; imported by the interface, the shift core and the top.
package sipo_pkg;

   localparam int FF_DEFAULT = 4;

   typedef enum logic {IDLE, COLLECT} col_state_e;
   typedef enum logic {EMPTY, FULL}   out_state_e;

endpackage

// File: rtl/sipo_collector_if.sv
// Serial-in / parallel-out bundle for sipo_collector; master drives the stream and consumes words.
// Pure wiring, no latency; par_ready is the only backpressure signal.
interface sipo_collector_if import sipo_pkg::*; #(parameter int FF = FF_DEFAULT) ();

   logic          sin;
   logic          sin_valid;
   logic          sync;
   logic [FF-1:0] par_data;
   logic          par_valid;
   logic          par_ready;
   logic          busy;
   logic          ovf;
   logic          ovf_clr;

   modport master (
      output sin, sin_valid, sync, par_ready, ovf_clr,
      input  par_data, par_valid, busy, ovf
   );

   modport slave (
      input  sin, sin_valid, sync, par_ready, ovf_clr,
      output par_data, par_valid, busy, ovf
   );

endinterface

// File: rtl/sipo_shift_core.sv
// LSB-first bit collector: shift register, bit counter and sync realignment; pulses done_o with word_o
// combinationally in the cycle the last bit is accepted. No backpressure: bits are always accepted.
module sipo_shift_core import sipo_pkg::*; #(
   parameter int FF = FF_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          sin_i,
   input  logic          sin_valid_i,
   input  logic          sync_i,
   output logic          done_o,
   output logic [FF-1:0] word_o,
   output logic          busy_o
);

   localparam int CW = (FF > 2) ? $clog2(FF) : 1;
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t LAST = cnt_t'(FF - 1);

   col_state_e    state_q, state_d;
   cnt_t          cnt_q, cnt_d;
   logic [FF-2:0] shreg_q, shreg_d;
   logic          busy_q;

   // Only FF-1 bits are stored: the incoming bit completes the word in the same cycle.
   assign word_o = {sin_i, shreg_q};
   assign busy_o = busy_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         busy_q  <= (cnt_d != '0);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      done_o  = 1'b0;
      if (sync_i) begin
         shreg_d = '0;
         cnt_d   = '0;
         state_d = IDLE;
         if (sin_valid_i) begin
            shreg_d[FF-2] = sin_i;
            cnt_d         = cnt_t'(1);
            state_d       = COLLECT;
         end
      end else if (sin_valid_i) begin
         shreg_d = word_o[FF-1:1];
         case (state_q)
            IDLE: begin
               cnt_d   = cnt_t'(1);
               state_d = COLLECT;
            end
            COLLECT: begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = IDLE;
                  done_o  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/sipo_collector.sv
// Reassembles an LSB-first bit stream into FF-bit words on a valid/ready port; word valid on the edge
// taking its last bit. A word completing while the port is full and not ready is dropped and sets ovf.
module sipo_collector import sipo_pkg::*; #(
   parameter int FF = FF_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   sipo_collector_if.slave sif
);

   logic          done;
   logic [FF-1:0] word;
   logic          busy;

   out_state_e    ost_q, ost_d;
   logic [FF-1:0] data_q, data_d;
   logic          ovf_q, ovf_d;

   sipo_shift_core #(.FF(FF)) u_core (
      .clk         (clk),
      .reset       (reset),
      .sin_i       (sif.sin),
      .sin_valid_i (sif.sin_valid),
      .sync_i      (sif.sync),
      .done_o      (done),
      .word_o      (word),
      .busy_o      (busy)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         ost_q  <= EMPTY;
         data_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         ost_q  <= ost_d;
         data_q <= data_d;
         ovf_q  <= ovf_d;
      end
   end

   always_comb begin
      ost_d  = ost_q;
      data_d = data_q;
      ovf_d  = ovf_q & ~sif.ovf_clr;
      if (done) begin
         // A handoff in the completion cycle frees the slot, so the new word loads without a bubble.
         if (ost_q == EMPTY || sif.par_ready) begin
            data_d = word;
            ost_d  = FULL;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (ost_q == FULL && sif.par_ready) begin
         ost_d = EMPTY;
      end
   end

   assign sif.par_data  = data_q;
   assign sif.par_valid = (ost_q == FULL);
   assign sif.busy      = busy;
   assign sif.ovf       = ovf_q;

endmodule

// File: tb/tb_sipo_collector.sv
// Bench for sipo_collector: directed vector table, set-wins sequence, then random stimulus vs a bit-queue model.
module tb_sipo_collector;
   import sipo_pkg::*;

   localparam int FF = 4;

   typedef struct {
      logic       rst;
      logic       sin;
      logic       sv;
      logic       sync;
      logic       rdy;
      logic       clr;
      logic       vld;
      logic [3:0] dat;
      logic       busy;
      logic       ovf;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sipo_collector_if #(.FF(FF)) sif ();

   sipo_collector #(.FF(FF)) dut (
      .clk   (clk),
      .reset (reset),
      .sif   (sif)
   );

   int n_cmp = 0;
   int n_bad = 0;
   vec_t tbl[$];

   function automatic vec_t v(input logic rst, sin, sv, sync, rdy, clr,
                              input logic vld, input logic [3:0] dat, input logic busy, ovf);
      vec_t r;
      r.rst = rst; r.sin = sin; r.sv = sv; r.sync = sync; r.rdy = rdy; r.clr = clr;
      r.vld = vld; r.dat = dat; r.busy = busy; r.ovf = ovf;
      return r;
   endfunction

   task automatic drive(input logic r, s, sv, sy, rd, c);
      reset         = r;
      sif.sin       = s;
      sif.sin_valid = sv;
      sif.sync      = sy;
      sif.par_ready = rd;
      sif.ovf_clr   = c;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic vld, input logic [3:0] dat,
                          input logic bsy, input logic ov);
      chk({tag, ".par_valid"}, 32'(sif.par_valid), 32'(vld));
      chk({tag, ".par_data"},  32'(sif.par_data),  32'(dat));
      chk({tag, ".busy"},      32'(sif.busy),      32'(bsy));
      chk({tag, ".ovf"},       32'(sif.ovf),       32'(ov));
   endtask

   initial begin
      bit         mq[$];
      logic       m_vld, m_ovf, m_busy;
      logic [3:0] m_dat;
      logic       r, s, sv, sy, rd, c;
      logic [3:0] w1, w2;
      int         w;

      drive(0, 0, 0, 0, 0, 0);

      //          rst sin sv sy rdy clr   vld dat  busy ovf
      tbl.push_back(v(0, 0, 0, 0, 0, 0,   0, 4'h0, 0, 0));
      // 1,1,1,1 continuous, ready high
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   0, 4'h0, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   0, 4'h0, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   0, 4'h0, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   1, 4'hF, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 0,   0, 4'hF, 0, 0));
      // 1,1,1,0 with 2-cycle gaps
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   0, 4'hF, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 0,   0, 4'hF, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 0,   0, 4'hF, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   0, 4'hF, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 0,   0, 4'hF, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 0,   0, 4'hF, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   0, 4'hF, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 0,   0, 4'hF, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 0,   0, 4'hF, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 1, 0,   1, 4'h7, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 0,   0, 4'h7, 0, 0));
      // A then 5 with ready low: second word dropped, ovf set, then cleared
      tbl.push_back(v(1, 0, 1, 0, 0, 0,   0, 4'h7, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 0,   0, 4'h7, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 0,   0, 4'h7, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 0,   1, 4'hA, 0, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 0,   1, 4'hA, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 0,   1, 4'hA, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 0,   1, 4'hA, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 0,   1, 4'hA, 0, 1));
      tbl.push_back(v(1, 0, 0, 0, 0, 0,   1, 4'hA, 0, 1));
      tbl.push_back(v(1, 0, 0, 0, 1, 1,   0, 4'hA, 0, 0));
      // 3 then C back to back, ready only on the second completion
      tbl.push_back(v(1, 1, 1, 0, 0, 0,   0, 4'hA, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 0,   0, 4'hA, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 0,   0, 4'hA, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 0,   1, 4'h3, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 0,   1, 4'h3, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 0,   1, 4'h3, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 0,   1, 4'h3, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   1, 4'hC, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 0,   0, 4'hC, 0, 0));
      // 1,0 then sync with a bit, then 0,1,1 -> D
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   0, 4'hC, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 1, 0,   0, 4'hC, 1, 0));
      tbl.push_back(v(1, 1, 1, 1, 1, 0,   0, 4'hC, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 1, 0,   0, 4'hC, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   0, 4'hC, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   1, 4'hD, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 0,   0, 4'hD, 0, 0));
      // reset mid-word, then 0,1,0,1 -> A
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   0, 4'hD, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   0, 4'hD, 1, 0));
      tbl.push_back(v(0, 1, 1, 0, 1, 0,   0, 4'h0, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 1, 0,   0, 4'h0, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   0, 4'h0, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 1, 0,   0, 4'h0, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   1, 4'hA, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 0,   0, 4'hA, 0, 0));
      // sync without a bit drops the partial word to count 0
      tbl.push_back(v(1, 1, 1, 0, 1, 0,   0, 4'hA, 1, 0));
      tbl.push_back(v(1, 0, 0, 1, 1, 0,   0, 4'hA, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 0,   0, 4'hA, 0, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].sin, tbl[i].sv, tbl[i].sync, tbl[i].rdy, tbl[i].clr);
         tick();
         chk_out($sformatf("row%0d", i), tbl[i].vld, tbl[i].dat, tbl[i].busy, tbl[i].ovf);
      end

      // Overflow coinciding with ovf_clr: set must win.
      w1 = 4'h1;
      w2 = 4'h2;
      for (int k = 0; k < FF; k++) begin
         drive(1, w1[k], 1, 0, 0, 0);
         tick();
      end
      chk_out("sw_load", 1, 4'h1, 0, 0);
      for (int k = 0; k < FF; k++) begin
         drive(1, w2[k], 1, 0, 0, (k == FF - 1));
         tick();
      end
      chk_out("sw_setwins", 1, 4'h1, 0, 1);
      drive(1, 0, 0, 0, 1, 1);
      tick();
      chk_out("sw_clear", 0, 4'h1, 0, 0);

      // Random phase: model keeps the accepted bits of the partial word in a queue.
      m_vld = 0; m_ovf = 0; m_dat = '0; m_busy = 0;
      for (int i = 0; i < 3000; i++) begin
         r  = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
         s  = 1'($urandom_range(0, 1));
         sv = ($urandom_range(0, 9) < 7);
         sy = ($urandom_range(0, 19) == 0);
         rd = ($urandom_range(0, 9) < 4);
         c  = ($urandom_range(0, 19) == 0);
         drive(r, s, sv, sy, rd, c);
         tick();
         if (!r) begin
            mq.delete();
            m_vld = 0; m_ovf = 0; m_dat = '0;
         end else begin
            w = -1;
            if (sy) begin
               mq.delete();
               if (sv) mq.push_back(s);
            end else if (sv) begin
               mq.push_back(s);
               if (mq.size() == FF) begin
                  w = 0;
                  foreach (mq[k]) w = w + (int'(mq[k]) << k);
                  mq.delete();
               end
            end
            if (c) m_ovf = 0;
            if (w >= 0) begin
               if (!m_vld || rd) begin
                  m_dat = 4'(w);
                  m_vld = 1;
               end else begin
                  m_ovf = 1;
               end
            end else if (m_vld && rd) begin
               m_vld = 0;
            end
         end
         m_busy = (mq.size() != 0);
         chk_out($sformatf("rnd%0d", i), m_vld, m_dat, m_busy, m_ovf);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
